// File: rtl/vga_timing_gen.sv
// Pixel-rate raster timing generator: registered x/y coordinates with sync,
// blanking and line/frame strobes that all describe the same pixel.
//
// State tables (horizontal phase on x, vertical phase on y):
//   state      | meaning
//   H_ST_ACT   | visible pixels, x in 0..H_DISPLAY-1
//   H_ST_FP    | horizontal front porch
//   H_ST_SYNC  | horizontal sync pulse
//   H_ST_BP    | horizontal back porch, ends when x wraps
//   V_ST_ACT   | visible lines, y in 0..V_DISPLAY-1
//   V_ST_FP    | vertical front porch
//   V_ST_SYNC  | vertical sync pulse
//   V_ST_BP    | vertical back porch, ends when y wraps
module vga_timing_gen #(
   parameter int unsigned H_DISPLAY   = 640,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned V_DISPLAY   = 480,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter bit          SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_ACT_LAST  = 10'(H_DISPLAY - 1);
   localparam logic [9:0] H_FP_LAST   = 10'(H_DISPLAY + H_FRONT - 1);
   localparam logic [9:0] H_SYNC_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_LAST  = 10'(V_DISPLAY - 1);
   localparam logic [9:0] V_FP_LAST   = 10'(V_DISPLAY + V_FRONT - 1);
   localparam logic [9:0] V_SYNC_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

   // Every phase must be at least one unit long so each state is visited.
   if (H_TOTAL > 1023 || V_TOTAL > 1023 ||
       H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
       V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
      $error("vga_timing_gen: timing parameters out of range");
   end

   typedef enum logic [1:0] {H_ST_ACT, H_ST_FP, H_ST_SYNC, H_ST_BP} h_state_t;
   typedef enum logic [1:0] {V_ST_ACT, V_ST_FP, V_ST_SYNC, V_ST_BP} v_state_t;

   h_state_t   h_state, h_nxt;
   v_state_t   v_state, v_nxt;
   logic [9:0] x_nxt, y_nxt;
   logic       x_wrap;
   logic       hsync_nxt, vsync_nxt, display_on_nxt, line_start_nxt, frame_start_nxt;
   logic [7:0] frame_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x           <= H_LAST;
         y           <= V_LAST;
         h_state     <= H_ST_BP;
         v_state     <= V_ST_BP;
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         display_on  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame       <= 8'hFF;
      end else begin
         x           <= x_nxt;
         y           <= y_nxt;
         h_state     <= h_nxt;
         v_state     <= v_nxt;
         hsync       <= hsync_nxt;
         vsync       <= vsync_nxt;
         display_on  <= display_on_nxt;
         line_start  <= line_start_nxt;
         frame_start <= frame_start_nxt;
         frame       <= frame_nxt;
      end
   end

   // Flags are derived from the next-state values so they land on the same
   // edge as the coordinates they describe.
   always_comb begin
      x_wrap = (x == H_LAST);
      x_nxt  = x_wrap ? 10'd0 : x + 10'd1;
      y_nxt  = y;
      if (x_wrap) begin
         y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
      end

      h_nxt = h_state;
      case (h_state)
         H_ST_ACT:  if (x == H_ACT_LAST)  h_nxt = H_ST_FP;
         H_ST_FP:   if (x == H_FP_LAST)   h_nxt = H_ST_SYNC;
         H_ST_SYNC: if (x == H_SYNC_LAST) h_nxt = H_ST_BP;
         H_ST_BP:   if (x_wrap)           h_nxt = H_ST_ACT;
         default:                         h_nxt = H_ST_BP;
      endcase

      v_nxt = v_state;
      if (x_wrap) begin
         case (v_state)
            V_ST_ACT:  if (y == V_ACT_LAST)  v_nxt = V_ST_FP;
            V_ST_FP:   if (y == V_FP_LAST)   v_nxt = V_ST_SYNC;
            V_ST_SYNC: if (y == V_SYNC_LAST) v_nxt = V_ST_BP;
            V_ST_BP:   if (y == V_LAST)      v_nxt = V_ST_ACT;
            default:                         v_nxt = V_ST_BP;
         endcase
      end

      hsync_nxt       = (h_nxt == H_ST_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_nxt       = (v_nxt == V_ST_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      display_on_nxt  = (h_nxt == H_ST_ACT) && (v_nxt == V_ST_ACT);
      line_start_nxt  = x_wrap;
      frame_start_nxt = x_wrap && (y == V_LAST);
      frame_nxt       = frame_start_nxt ? frame + 8'd1 : frame;
   end

endmodule
